mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline: sits between ex_mem and mem_wb.
//  Non-memory ops pass wd/wreg/wdata through combinationally. Loads and stores run a
//  req/ack transaction on the data bus, with byte-lane selection and sign/zero extension.
//  While a transaction is in flight the block raises stallreq_o to ctrl; mem_wb bubbles meanwhile.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles in REQ without dbus_ack before abort (1..255, 8-bit counter)
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   synchronous, active-high reset
//  stall         in   6   pipeline stall vector from ctrl; bit 4 = MEM stage held
//  wd_i          in   5   dest reg addr from ex_mem
//  wreg_i        in   1   dest write enable from ex_mem
//  wdata_i       in   32  ALU result from ex_mem
//  aluop_i       in   8   op code; load/store codes per shared defines
//  mem_addr_i    in   32  effective byte address
//  reg2_i        in   32  store source data
//  wd_o          out  5   to mem_wb
//  wreg_o        out  1   to mem_wb
//  wdata_o       out  32  to mem_wb
//  stallreq_o    out  1   stall request to ctrl
//  dbus_req_o    out  1   bus request, held high for the whole REQ state
//  dbus_we_o     out  1   1 = store
//  dbus_addr_o   out  32  word-aligned address {addr[31:2],2'b00}
//  dbus_sel_o    out  4   byte lanes, big-endian (addr[1:0]=00 -> 4'b1000)
//  dbus_wdata_o  out  32  store data replicated across lanes
//  dbus_rdata_i  in   32  load data, valid with ack
//  dbus_ack_i    in   1   transaction done, sampled only in REQ
//  excp_o        out  1   one-cycle pulse: misaligned access or bus timeout
// BEHAVIOUR
//  States: IDLE, REQ, DONE (2-bit state register, synchronous).
//  Reset values: state=IDLE, rdata_q=0, tmo_cnt=0.
//    All outputs combinational from state and inputs; in IDLE with a non-mem op they are
//    wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, all dbus_* = 0, stallreq_o = 0, excp_o = 0.
//  Load/store codes: LB E0, LH E1, LW E3, LBU E4, LHU E5, SB E8, SH E9, SW EB.
//    All other aluop values are non-mem and pass through with no state change.
//  IDLE, mem op:
//    Misaligned case: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//      excp_o=1 for that cycle, wreg_o=0, no bus activity, stay IDLE.
//    Otherwise stallreq_o=1 and the next state is REQ.
//  REQ: dbus_req_o=1; stallreq_o=1; wreg_o=0.
//    dbus_ack_i=1: capture rdata_q <= dbus_rdata_i, clear tmo_cnt, go to DONE.
//    No ack: tmo_cnt+1. When tmo_cnt reaches TIMEOUT_CYC-1 with no ack:
//      excp_o=1, drop dbus_req_o, then go to DONE with wreg_o forced to 0.
//  DONE: stallreq_o=0, dbus_req_o=0.
//    Result to mem_wb: wd_o=wd_i, wreg_o=wreg_i, with wreg_o forced 0 for stores and timeouts.
//    wdata_o for loads = the selected lane of rdata_q, sign- or zero-extended.
//    Holds while stall[4]=1. Returns to IDLE on the first cycle with stall[4]=0.
//    The held ex_mem instruction is never reissued.
//  Latency: a mem op with ack in the first REQ cycle reaches mem_wb 2 cycles after entering
//    MEM. Non-mem ops have 0 added latency.
//  Stores: SB puts reg2_i[7:0] on all 4 lanes; SH puts reg2_i[15:0] on both halves;
//    SW sends reg2_i unchanged.
//  Reset during REQ: rst wins; state goes to IDLE and dbus_req_o drops in the same cycle.
//    No ack is expected afterwards; a stray ack in IDLE is ignored.
//  Simultaneous ack and timeout: the ack wins.
// STRUCTURE
//  Shared define.vh: aluop load/store codes, RegBus/RegAddrBus widths, Stop/NoStop,
//    RstEnable, ZeroWord.
//  One sub-module, mem_lane_mux (combinational):
//    inputs aluop, addr[1:0], reg2 and rdata; outputs sel, store data and extended load data.
//  The FSM and the timeout counter live in mem_access.
// TESTING
//  1. ADD pass-through: wd_i=3, wreg_i=1, wdata_i=0x1234 -> same values on outputs in the
//     same cycle; stallreq_o=0.
//  2. LB, addr=0x1001, ack on 1st REQ cycle, rdata=0x11F23344
//     -> dbus_sel_o=0100, wdata_o=0xFFFFFFF2.
//     Same access as LBU -> wdata_o=0x000000F2.
//  3. SH, addr=0x2002, reg2_i=0xAABBCCDD
//     -> dbus_we_o=1, sel=0011, dbus_wdata_o=0xCCDDCCDD; DONE has wreg_o=0.
//  4. LW, addr=0x3002 -> excp_o pulses 1 cycle, dbus_req_o stays 0, wreg_o=0.
//  5. LW with ack withheld and TIMEOUT_CYC=4 -> req held exactly 4 cycles, excp_o pulse,
//     stallreq_o drops, wreg_o=0.
//  6. LW with ack delayed 3 cycles, rst asserted in the 2nd REQ cycle
//     -> next cycle state=IDLE, dbus_req_o=0, stallreq_o=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared aluop load/store codes, bus widths and access-size decode
// used by the MEM stage and its lane mux.
package mem_access_pkg;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic             STOP       = 1'b1;
    localparam logic             NO_STOP    = 1'b0;
    localparam logic             RST_ENABLE = 1'b1;
    localparam logic [REG_W-1:0] ZERO_WORD  = '0;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_e acc_size(input logic [7:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return SZ_BYTE;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return SZ_HALF;
        if (op inside {OP_LW, OP_SW}) return SZ_WORD;
        return SZ_NONE;
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
        return (acc_size(op) == SZ_HALF && a[0]) || (acc_size(op) == SZ_WORD && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: big-endian byte-lane select, store-data replication and
// sign/zero extension of the selected load lane.
module mem_lane_mux
    import mem_access_pkg::*;
(
    input  logic [7:0]       aluop_i,
    input  logic [1:0]       addr_i,
    input  logic [REG_W-1:0] reg2_i,
    input  logic [REG_W-1:0] rdata_i,
    output logic [3:0]       sel_o,
    output logic [REG_W-1:0] st_data_o,
    output logic [REG_W-1:0] ld_data_o
);
    size_e       sz;
    logic [7:0]  b;
    logic [15:0] h;

    assign sz = acc_size(aluop_i);
    // Byte 0 of the word sits in bits 31:24, so shift by (3 - addr) bytes.
    assign b  = 8'(rdata_i >> {~addr_i, 3'b000});
    assign h  = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    assign sel_o = sz == SZ_BYTE ? 4'b1000 >> addr_i :
                   sz == SZ_HALF ? (addr_i[1] ? 4'b0011 : 4'b1100) :
                   sz == SZ_WORD ? 4'b1111 : 4'b0000;

    assign st_data_o = sz == SZ_BYTE ? {4{reg2_i[7:0]}} :
                       sz == SZ_HALF ? {2{reg2_i[15:0]}} : reg2_i;

    assign ld_data_o = aluop_i == OP_LB  ? {{24{b[7]}}, b} :
                       aluop_i == OP_LBU ? {24'b0, b} :
                       aluop_i == OP_LH  ? {{16{h[15]}}, h} :
                       aluop_i == OP_LHU ? {16'b0, h} : rdata_i;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage; passes ALU results through and runs load/store
// req/ack transactions on the data bus with a bounded wait for ack.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [7:0]            aluop_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  stallreq_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [REG_W-1:0]      dbus_addr_o,
    output logic [3:0]            dbus_sel_o,
    output logic [REG_W-1:0]      dbus_wdata_o,
    input  logic [REG_W-1:0]      dbus_rdata_i,
    input  logic                  dbus_ack_i,
    output logic                  excp_o
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e           state_q;
    logic [REG_W-1:0] rdata_q;
    logic [7:0]       tmo_cnt_q;
    logic             tmo_q;
    logic             ld, st, mis, go, in_idle, in_req, in_done, tmo_hit, unused_stall;
    logic [3:0]       sel;
    logic [REG_W-1:0] st_data, ld_data;

    mem_lane_mux u_lane (
        .aluop_i   (aluop_i),
        .addr_i    (mem_addr_i[1:0]),
        .reg2_i    (reg2_i),
        .rdata_i   (rdata_q),
        .sel_o     (sel),
        .st_data_o (st_data),
        .ld_data_o (ld_data)
    );

    assign ld           = is_load(aluop_i);
    assign st           = is_store(aluop_i);
    assign mis          = misaligned(aluop_i, mem_addr_i[1:0]);
    assign in_idle      = state_q == IDLE;
    assign in_req       = state_q == REQ;
    assign in_done      = state_q == DONE;
    assign go           = in_idle && (ld || st) && !mis;
    // An ack arriving on the last allowed cycle still completes the access.
    assign tmo_hit      = in_req && !dbus_ack_i && tmo_cnt_q == TMO_LAST;
    assign unused_stall = ^{stall[5], stall[3:0]};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= IDLE;
            rdata_q   <= ZERO_WORD;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    state_q <= REQ;
                    tmo_q   <= 1'b0;
                end
                REQ: if (dbus_ack_i) begin
                    rdata_q   <= dbus_rdata_i;
                    tmo_cnt_q <= '0;
                    state_q   <= DONE;
                end else if (tmo_hit) begin
                    tmo_cnt_q <= '0;
                    tmo_q     <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                end
                DONE: if (!stall[4]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wd_o         = wd_i;
    assign wreg_o       = in_idle ? (wreg_i && !mis) : (in_done && wreg_i && !st && !tmo_q);
    assign wdata_o      = (in_done && ld) ? ld_data : wdata_i;
    assign stallreq_o   = (go || in_req) ? STOP : NO_STOP;
    assign excp_o       = (in_idle && mis) || tmo_hit;
    assign dbus_req_o   = in_req;
    assign dbus_we_o    = in_req && st;
    assign dbus_addr_o  = in_req ? {mem_addr_i[REG_W-1:2], 2'b00} : ZERO_WORD;
    assign dbus_sel_o   = in_req ? sel : 4'b0000;
    assign dbus_wdata_o = dbus_we_o ? st_data : ZERO_WORD;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for the MEM stage with a bus responder
// and a reference model of load/store results computed arithmetically.
module tb_mem_access;
    localparam int TMO = 4;
    localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
    localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          excp;
        int          req;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
    } bus_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  stall;
    logic [4:0]  wd_i = '0, wd_o;
    logic        wreg_i = 1'b0, wreg_o;
    logic [31:0] wdata_i = '0, wdata_o, mem_addr_i = '0, reg2_i = '0;
    logic [7:0]  aluop_i = '0;
    logic        stallreq_o, dbus_req_o, dbus_we_o, excp_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i = '0;
    logic [3:0]  dbus_sel_o;
    logic        dbus_ack_i = 1'b0;
    logic        s4, hold_act = 1'b0, stray = 1'b0, ex_valid = 1'b0;
    int          n_chk = 0, n_fail = 0;
    exp_t        sb[$];
    bus_t        bq[$];
    logic [7:0]  ops [14] = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB,
                              8'h20, 8'h21, 8'h00, 8'hE2, 8'hE6, 8'hEA};

    assign s4    = stallreq_o | hold_act;
    assign stall = {1'b0, {5{s4}}};

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .stall(stall), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i),
        .dbus_ack_i(dbus_ack_i), .excp_o(excp_o)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: pushes the expected retire record and bus transaction, then drives
    // the instruction like ex_mem would, holding it until the MEM stage releases it.
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] wdat, input logic [4:0] wd, input logic wr,
                         input int dly, input logic [31:0] rd, input int hold);
        int sz, k, guard, hold_left;
        logic is_ld, is_st, mis, tmo;
        logic [31:0] v;
        exp_t e;
        bus_t b;
        sz    = (op inside {LB, LBU, SB}) ? 1 : (op inside {LH, LHU, SH}) ? 2 : (op inside {LW, SW}) ? 4 : 0;
        is_ld = op inside {LB, LH, LW, LBU, LHU};
        is_st = op inside {SB, SH, SW};
        k     = int'(addr % 4);
        mis   = sz != 0 && (k % sz) != 0;
        tmo   = dly >= TMO;
        if (sz == 1) begin
            v = (rd >> (8 * (3 - k))) & 32'hFF;
            if (op == LB && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = (rd >> (8 * (2 - k))) & 32'hFFFF;
            if (op == LH && v >= 32768) v = v - 65536;
        end else v = rd;
        e.wd = wd;
        if (sz == 0) begin
            e.wreg = wr; e.wdata = wdat; e.chk_wdata = 1'b1; e.excp = 0; e.req = 0;
        end else if (mis) begin
            e.wreg = 1'b0; e.wdata = wdat; e.chk_wdata = 1'b0; e.excp = 1; e.req = 0;
            hold = 0;
        end else begin
            e.wreg = is_ld && wr && !tmo; e.wdata = v; e.chk_wdata = e.wreg;
            e.excp = tmo ? 1 : 0; e.req = tmo ? TMO : dly + 1;
            b.addr  = addr - 32'(k);
            b.sel   = sz == 4 ? 4'd15 : sz == 2 ? 4'(3 << (2 - k)) : 4'(1 << (3 - k));
            b.we    = is_st;
            b.wdata = !is_st ? 32'h0 : sz == 1 ? (reg2 & 32'hFF) * 32'h01010101 :
                      sz == 2 ? (reg2 & 32'hFFFF) * 32'h00010001 : reg2;
            b.dly   = dly;
            b.rdata = rd;
            bq.push_back(b);
        end
        sb.push_back(e);
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = wdat; wd_i = wd; wreg_i = wr;
        ex_valid = 1'b1;
        hold_left = hold;
        guard = 0;
        forever begin
            #1;
            hold_act = !stallreq_o && hold_left > 0;
            if (hold_act) hold_left--;
            #2;
            if (!stall[4]) break;
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                n_chk++; n_fail++;
                $display("FAIL retire_bound: op %h still stalled after %0d cycles", op, guard);
                break;
            end
        end
        @(negedge clk);
        ex_valid = 1'b0; hold_act = 1'b0; aluop_i = 8'h00; wreg_i = 1'b0;
    endtask

    // Bus responder: acks after the scheduled delay and checks the request fields.
    initial begin
        int   rcnt;
        bus_t cur;
        rcnt = 0;
        cur.dly = 0; cur.rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rcnt = 0; dbus_ack_i = 1'b0;
                continue;
            end
            if (dbus_req_o) begin
                if (rcnt == 0) begin
                    if (bq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL bus_unexpected: req at addr %h, none expected", dbus_addr_o);
                        cur.dly = 0; cur.rdata = '0;
                    end else begin
                        cur = bq.pop_front();
                        chk("bus_addr", dbus_addr_o, cur.addr);
                        chk("bus_sel", 32'(dbus_sel_o), 32'(cur.sel));
                        chk("bus_we", 32'(dbus_we_o), 32'(cur.we));
                        chk("bus_wdata", dbus_wdata_o, cur.wdata);
                    end
                end
                dbus_ack_i   = rcnt == cur.dly;
                dbus_rdata_i = dbus_ack_i ? cur.rdata : $urandom;
                rcnt++;
            end else begin
                rcnt = 0;
                dbus_ack_i   = stray;
                dbus_rdata_i = $urandom;
            end
        end
    end

    // Monitor: whenever an instruction leaves MEM, compare it with the oldest expectation.
    initial begin
        int   ex_cnt, rq_cnt;
        exp_t e;
        ex_cnt = 0; rq_cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                ex_cnt = 0; rq_cnt = 0;
                continue;
            end
            ex_cnt += int'(excp_o);
            rq_cnt += int'(dbus_req_o);
            if (ex_valid && !stall[4]) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL retire_unexpected: wd %0d wdata %h", wd_o, wdata_o);
                end else begin
                    e = sb.pop_front();
                    chk("wd", 32'(wd_o), 32'(e.wd));
                    chk("wreg", 32'(wreg_o), 32'(e.wreg));
                    if (e.chk_wdata) chk("wdata", wdata_o, e.wdata);
                    chk("excp_pulses", 32'(ex_cnt), 32'(e.excp));
                    chk("req_cycles", 32'(rq_cnt), 32'(e.req));
                end
                ex_cnt = 0; rq_cnt = 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hCAFE0001; aluop_i = 8'h21;
        #3;
        chk("rst_stallreq", 32'(stallreq_o), 32'd0);
        chk("rst_req", 32'(dbus_req_o), 32'd0);
        chk("rst_excp", 32'(excp_o), 32'd0);
        chk("rst_sel", 32'(dbus_sel_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'hCAFE0001);
        @(negedge clk);
        rst = 1'b0;

        issue(8'h20, 32'h0000_0040, 32'h0, 32'h1234, 5'd3, 1'b1, 0, 32'h0, 0);
        issue(LB,  32'h1001, 32'h0, 32'h0, 5'd5, 1'b1, 0, 32'h11F23344, 0);
        issue(LBU, 32'h1001, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h11F23344, 0);
        issue(SH,  32'h2002, 32'hAABBCCDD, 32'h0, 5'd8, 1'b1, 0, 32'h0, 0);
        issue(LW,  32'h3002, 32'h0, 32'h0, 5'd9, 1'b1, 0, 32'h0, 0);
        issue(LW,  32'h4000, 32'h0, 32'h0, 5'd10, 1'b1, 10, 32'h0, 0);
        issue(LH,  32'h4002, 32'h0, 32'h0, 5'd11, 1'b1, TMO - 1, 32'h1234_8001, 2);

        // Reset in the second REQ cycle of a slow load.
        begin
            bus_t b;
            b.addr = 32'h5000; b.sel = 4'hF; b.we = 1'b0; b.wdata = 32'h0; b.dly = 3; b.rdata = 32'h0;
            bq.push_back(b);
            aluop_i = LW; mem_addr_i = 32'h5000; wreg_i = 1'b1;
            @(negedge clk);
            #3;
            chk("rq_req_active", 32'(dbus_req_o), 32'd1);
            @(negedge clk);
            rst = 1'b1; aluop_i = 8'h00; wreg_i = 1'b0;
            @(negedge clk);
            rst = 1'b0; stray = 1'b1;
            #3;
            chk("rq_req_dropped", 32'(dbus_req_o), 32'd0);
            chk("rq_stallreq", 32'(stallreq_o), 32'd0);
            @(negedge clk);
            #3;
            chk("stray_ack_req", 32'(dbus_req_o), 32'd0);
            chk("stray_ack_excp", 32'(excp_o), 32'd0);
            @(negedge clk);
            stray = 1'b0;
            @(negedge clk);
        end

        for (int i = 0; i < 200; i++) begin
            issue(ops[$urandom_range(0, 13)], $urandom, $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("bus_drained", 32'(bq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
